// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC generation, req/ack memory port, instruction buffer
//
// Fetches 32-bit words through a single-outstanding req/ack port and buffers up to DEPTH words
// with their PCs. The head word is presented to decode with a ready level and a toggle trigger.
// A branch flushes the buffer and restarts fetching at the new target.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   memReq, memAddr         read request (held until memAck) and word-aligned address
//   memAck, memData         one-cycle acknowledge with the returned word
//   dataOut, pcOut          head instruction word and its PC
//   readyOut, triggerOut    buffer non-empty; toggles once per new head word
//   ackIn                   decode consumes the head word
//   branchIn, branchAddr    redirect request and target
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] dataOut,
    output logic [31:0] pcOut,
    output logic        readyOut,
    output logic        triggerOut,
    input  logic        ackIn,
    input  logic        branchIn,
    input  logic [31:0] branchAddr
);

    localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [31:0]     RESET_ADDR = {RESET_PC[31:2], 2'b00};
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);

    typedef enum logic {
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [31:0]     pc;
    logic            discard;
    logic [CW-1:0]   count;
    logic [PW-1:0]   headPtr;
    logic [PW-1:0]   tailPtr;
    logic [PW-1:0]   headNext;
    logic [PW-1:0]   tailNext;
    logic [31:0]     dataBuf [DEPTH];
    logic [31:0]     pcBuf   [DEPTH];
    logic            issue;
    logic            ackTaken;
    logic            push;
    logic            pop;
    logic            headNew;
    logic            headAdvance;
    logic            unusedBranchLsb;

    assign unusedBranchLsb = &{1'b0, branchAddr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ISSUE;
        end else begin
            state <= nextState;
        end
    end

    // Only one request is ever outstanding, so in ISSUE the in-flight count is zero and the
    // room check reduces to count < DEPTH. A branch cycle never issues: the pc is being
    // replaced, and the next cycle issues from the new target.
    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        issue     = 1'b0;
        ackTaken  = 1'b0;
        case (state)
            S_ISSUE: begin
                if (!branchIn && (count < FULL_COUNT)) begin
                    issue     = 1'b1;
                    nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                memReq = 1'b1;
                if (memAck) begin
                    ackTaken  = 1'b1;
                    nextState = S_ISSUE;
                end
            end
            default: nextState = S_ISSUE;
        endcase
    end

    assign push     = ackTaken && !discard && !branchIn;
    assign pop      = ackIn && (count != '0) && !branchIn;
    assign headNext = (headPtr == LAST_PTR) ? '0 : headPtr + PW'(1);
    assign tailNext = (tailPtr == LAST_PTR) ? '0 : tailPtr + PW'(1);

    // A new head appears either when a word lands in an empty buffer (or replaces the last
    // word being popped), or when a pop exposes an entry already waiting behind the head.
    assign headNew     = push && ((count == '0) || (pop && (count == CW'(1))));
    assign headAdvance = pop && (count > CW'(1));
    assign readyOut    = (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            memAddr    <= RESET_ADDR;
            pc         <= RESET_ADDR;
            discard    <= 1'b0;
            count      <= '0;
            headPtr    <= '0;
            tailPtr    <= '0;
            dataOut    <= '0;
            pcOut      <= '0;
            triggerOut <= 1'b0;
        end else begin
            if (issue) begin
                memAddr <= pc;
            end

            if (branchIn) begin
                pc <= {branchAddr[31:2], 2'b00};
            end else if (push) begin
                pc <= pc + 32'd4;
            end

            // The request in flight at a branch still completes; its word is thrown away.
            if (ackTaken) begin
                discard <= 1'b0;
            end else if (branchIn && (state == S_WAIT)) begin
                discard <= 1'b1;
            end

            if (branchIn) begin
                count   <= '0;
                headPtr <= '0;
                tailPtr <= '0;
            end else begin
                if (push) begin
                    tailPtr <= tailNext;
                end
                if (pop) begin
                    headPtr <= headNext;
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end

            if (headNew) begin
                dataOut    <= memData;
                pcOut      <= memAddr;
                triggerOut <= ~triggerOut;
            end else if (headAdvance) begin
                dataOut    <= dataBuf[headNext];
                pcOut      <= pcBuf[headNext];
                triggerOut <= ~triggerOut;
            end
        end
    end

    // Buffer storage carries no reset; validity is tracked entirely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            dataBuf[tailPtr] <= memData;
            pcBuf[tailPtr]   <= memAddr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a random-latency memory model
module tb_fetch_stage;

    localparam logic [31:0] RPC   = 32'hFFFF_FFFC;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic [31:0] dataOut;
    logic [31:0] pcOut;
    logic        readyOut;
    logic        triggerOut;
    logic        ackIn;
    logic        branchIn;
    logic [31:0] branchAddr;

    fetch_stage #(
        .RESET_PC(RPC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memAck    (memAck),
        .memData   (memData),
        .dataOut   (dataOut),
        .pcOut     (pcOut),
        .readyOut  (readyOut),
        .triggerOut(triggerOut),
        .ackIn     (ackIn),
        .branchIn  (branchIn),
        .branchAddr(branchAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Stimulus knobs and memory model state
    int          minLat      = 0;
    int          maxLat      = 0;
    int          ackPct      = 0;
    int          brPct       = 0;
    int          waitCnt     = -1;
    int          memAcks     = 0;
    bit          forceAck    = 0;
    bit          forceBranch = 0;
    logic [31:0] forceTarget = '0;
    logic [31:0] segQ [$];

    task automatic step();
        @(negedge clk);
        memAck   = 1'b0;
        ackIn    = 1'b0;
        branchIn = 1'b0;
        if (reset) begin
            waitCnt = -1;
            if (forceAck) begin
                memAck  = 1'b1;
                memData = 32'hDEAD_BEEF;
            end
        end else begin
            if (memReq) begin
                if (waitCnt < 0) waitCnt = int'($urandom_range(maxLat, minLat));
                if (waitCnt == 0) begin
                    memAck  = 1'b1;
                    memData = memWord(memAddr);
                    memAcks++;
                    waitCnt = -1;
                end else begin
                    waitCnt--;
                end
            end
            if (int'($urandom_range(99, 0)) < ackPct) ackIn = 1'b1;
            if (forceBranch || (int'($urandom_range(99, 0)) < brPct)) begin
                branchIn   = 1'b1;
                branchAddr = forceBranch ? forceTarget : $urandom;
                segQ.push_back({branchAddr[31:2], 2'b00});
            end
        end
    endtask

    // Monitor: the expected instruction stream is consecutive PCs from the last reset or branch.
    bit          pTrig = 0;
    bit          pReady = 0;
    bit          pReq = 0;
    logic [31:0] pData = '0;
    logic [31:0] pPc = '0;
    logic [31:0] pAddr = '0;
    logic [31:0] nextPc = RPC;
    bit          expectAddrValid = 0;
    logic [31:0] expectAddr = '0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            check("rst_memReq", {31'd0, memReq}, 32'd0);
            check("rst_ready", {31'd0, readyOut}, 32'd0);
            check("rst_trigger", {31'd0, triggerOut}, 32'd0);
            check("rst_memAddr", memAddr, RPC);
            check("rst_dataOut", dataOut, 32'd0);
            check("rst_pcOut", pcOut, 32'd0);
            nextPc = RPC;
            segQ.delete();
            expectAddrValid = 1;
            expectAddr = RPC;
        end else begin
            if (branchIn) begin
                check("branch_flush_ready", {31'd0, readyOut}, 32'd0);
                if (segQ.size() == 0) begin
                    check("branch_scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    nextPc = segQ.pop_front();
                end
                expectAddrValid = 1;
                expectAddr = nextPc;
            end
            if (triggerOut != pTrig) begin
                check("head_ready", {31'd0, readyOut}, 32'd1);
                check("head_pc", pcOut, nextPc);
                check("head_data", dataOut, memWord(nextPc));
                nextPc = nextPc + 32'd4;
            end else begin
                if (pReady && ackIn && !branchIn && readyOut)
                    check("pop_trigger", {31'd0, triggerOut}, {31'd0, ~pTrig});
                if (pReady && readyOut) begin
                    check("hold_pc", pcOut, pPc);
                    check("hold_data", dataOut, pData);
                end
            end
            if (pReq && memAck) begin
                check("req_drop", {31'd0, memReq}, 32'd0);
            end else if (pReq && memReq) begin
                check("addr_hold", memAddr, pAddr);
            end
            if (!pReq && memReq) begin
                check("addr_align", {30'd0, memAddr[1:0]}, 32'd0);
                if (expectAddrValid) begin
                    check("first_addr", memAddr, expectAddr);
                    expectAddrValid = 0;
                end
            end
        end
        pTrig  = triggerOut;
        pReady = readyOut;
        pReq   = memReq;
        pData  = dataOut;
        pPc    = pcOut;
        pAddr  = memAddr;
    end

    task automatic waitReq(input string name);
        int n = 0;
        while (!memReq && n < 20) begin
            step();
            n++;
        end
        check(name, {31'd0, memReq}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        memAck     = 1'b0;
        memData    = '0;
        ackIn      = 1'b0;
        branchIn   = 1'b0;
        branchAddr = '0;

        // Zero-wait memory, decode always acks: first request, stream order, wrap past 0xFFFFFFFC
        ackPct = 100;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("t1_req", {31'd0, memReq}, 32'd1);
        check("t1_addr", memAddr, RPC);
        repeat (20) step();

        // Decode stalls: buffer fills to DEPTH, then one ack allows exactly one more fetch
        reset = 1'b1;
        ackPct = 0;
        maxLat = 2;
        repeat (2) step();
        reset = 1'b0;
        memAcks = 0;
        repeat (40) step();
        check("t3_words", memAcks, DEPTH);
        check("t3_stall", {31'd0, memReq}, 32'd0);
        check("t3_ready", {31'd0, readyOut}, 32'd1);
        ackPct = 100;
        step();
        ackPct = 0;
        repeat (30) step();
        check("t3_one_more", memAcks, DEPTH + 1);
        check("t3_stall2", {31'd0, memReq}, 32'd0);

        // Branch to 0x103 while a slow request is pending
        reset = 1'b1;
        minLat = 5;
        maxLat = 5;
        repeat (2) step();
        reset = 1'b0;
        waitReq("t4_req_seen");
        forceBranch = 1;
        forceTarget = 32'h0000_0103;
        step();
        forceBranch = 0;
        repeat (30) step();
        check("t4_head_pc", pcOut, 32'h0000_0100);
        check("t4_ready", {31'd0, readyOut}, 32'd1);

        // Reset mid-WAIT with a stray ack during reset
        reset = 1'b1;
        minLat = 4;
        maxLat = 4;
        repeat (2) step();
        reset = 1'b0;
        waitReq("t6_req_seen");
        step();
        reset = 1'b1;
        forceAck = 1;
        step();
        forceAck = 0;
        step();
        reset = 1'b0;
        step();
        check("t6_empty", {31'd0, readyOut}, 32'd0);
        repeat (20) step();
        check("t6_head_pc", pcOut, RPC);

        // Random traffic with branches and occasional resets
        reset = 1'b1;
        minLat = 0;
        maxLat = 3;
        ackPct = 50;
        brPct = 4;
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(299, 0) == 0) begin
                reset = 1'b1;
                step();
                step();
                reset = 1'b0;
            end
        end
        brPct = 0;
        ackPct = 0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
